// File: rtl/mem_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_pkg
// Description : Shared constants and MEM/WB stage action encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pipe_pkg;

    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;

    localparam logic [RegBusW-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBusW-1:0] NOPRegAddr = '0;

    typedef enum logic [1:0] {
        MemWbActFlush   = 2'd0,
        MemWbActBubble  = 2'd1,
        MemWbActCapture = 2'd2,
        MemWbActHold    = 2'd3
    } mem_wb_act_e;

    // Flush beats any stall; a bubble is inserted only when downstream keeps moving.
    function automatic mem_wb_act_e mem_wb_decode(input logic flush,
                                                  input logic stall_cur,
                                                  input logic stall_next);
        if (flush)
            return MemWbActFlush;
        if (stall_cur == Stop && stall_next == NoStop)
            return MemWbActBubble;
        if (stall_cur == NoStop)
            return MemWbActCapture;
        return MemWbActHold;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_pipe_wreg_collide.sv
`default_nettype none
// ============================================================================
// Module      : wreg_collide
// Description : Same-bundle GPR write collision resolution; the highest
//               channel writing a given address keeps its enable.
// Revision    : 1.0 - initial release
// ============================================================================
module wreg_collide
#(
    parameter int NCH = 2,
    parameter int AW  = 5
)(
    input  logic [NCH-1:0]    i_wreg,
    input  logic [NCH*AW-1:0] i_wd,
    output logic [NCH-1:0]    o_wreg
);

    always_comb begin
        o_wreg = i_wreg;
        for (int i = 0; i < NCH; i++) begin
            for (int j = i + 1; j < NCH; j++) begin
                if (i_wreg[i] && i_wreg[j] && (i_wd[i*AW +: AW] == i_wd[j*AW +: AW]))
                    o_wreg[i] = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline register with flush, stage-valid, write
//               collision resolution and $zero write suppression.
//               Optional perf counters: MEM_WB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int STAGE_IDX = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [NCH-1:0]    mem_wreg,
    input  logic [NCH*AW-1:0] mem_wd,
    input  logic [NCH*DW-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DW-1:0]     mem_hi,
    input  logic [DW-1:0]     mem_lo,
    input  logic              mem_LLbit_we,
    input  logic              mem_LLbit_value,
    input  logic              mem_cp0_reg_we,
    input  logic [4:0]        mem_cp0_reg_write_addr,
    input  logic [DW-1:0]     mem_cp0_reg_data,
    output logic              wb_valid,
    output logic [NCH-1:0]    wb_wreg,
    output logic [NCH*AW-1:0] wb_wd,
    output logic [NCH*DW-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DW-1:0]     wb_hi,
    output logic [DW-1:0]     wb_lo,
    output logic              wb_LLbit_we,
    output logic              wb_LLbit_value,
    output logic              wb_cp0_reg_we,
    output logic [4:0]        wb_cp0_reg_write_addr,
    output logic [DW-1:0]     wb_cp0_reg_data,
    output logic [15:0]       perf_bubble_cnt,
    output logic [15:0]       perf_hold_cnt
);

    typedef struct packed {
        logic              valid;
        logic [NCH-1:0]    wreg;
        logic [NCH*AW-1:0] wd;
        logic [NCH*DW-1:0] wdata;
        logic              whilo;
        logic [DW-1:0]     hi;
        logic [DW-1:0]     lo;
        logic              llbit_we;
        logic              llbit_value;
        logic              cp0_we;
        logic [4:0]        cp0_addr;
        logic [DW-1:0]     cp0_data;
    } bundle_t;

    mem_wb_act_e    w_act;
    logic [NCH-1:0] w_wreg_res;
    logic [NCH-1:0] w_wd_nz;
    bundle_t        w_cap;
    bundle_t        w_next;
    bundle_t        r_bundle;
    logic           w_unused_stall;

    assign w_act          = mem_wb_decode(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);
    assign w_unused_stall = ^stall;

    wreg_collide #(
        .NCH (NCH),
        .AW  (AW)
    ) u_wreg_collide (
        .i_wreg (mem_wreg),
        .i_wd   (mem_wd),
        .o_wreg (w_wreg_res)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_zero_sup
            assign w_wd_nz[gi] = (mem_wd[gi*AW +: AW] != '0);
        end
    endgenerate

    // Data is captured even for an invalid slot; only the enables are killed.
    always_comb begin
        w_cap             = '0;
        w_cap.valid       = mem_valid;
        w_cap.wreg        = w_wreg_res & w_wd_nz & {NCH{mem_valid}};
        w_cap.wd          = mem_wd;
        w_cap.wdata       = mem_wdata;
        w_cap.whilo       = mem_whilo & mem_valid;
        w_cap.hi          = mem_hi;
        w_cap.lo          = mem_lo;
        w_cap.llbit_we    = mem_LLbit_we & mem_valid;
        w_cap.llbit_value = mem_LLbit_value;
        w_cap.cp0_we      = mem_cp0_reg_we & mem_valid;
        w_cap.cp0_addr    = mem_cp0_reg_write_addr;
        w_cap.cp0_data    = mem_cp0_reg_data;
    end

    always_comb begin
        w_next = r_bundle;
        case (w_act)
            MemWbActFlush,
            MemWbActBubble:  w_next = '0;
            MemWbActCapture: w_next = w_cap;
            default:         w_next = r_bundle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_bundle <= '0;
        else
            r_bundle <= w_next;
    end

    assign wb_valid              = r_bundle.valid;
    assign wb_wreg               = r_bundle.wreg;
    assign wb_wd                 = r_bundle.wd;
    assign wb_wdata              = r_bundle.wdata;
    assign wb_whilo              = r_bundle.whilo;
    assign wb_hi                 = r_bundle.hi;
    assign wb_lo                 = r_bundle.lo;
    assign wb_LLbit_we           = r_bundle.llbit_we;
    assign wb_LLbit_value        = r_bundle.llbit_value;
    assign wb_cp0_reg_we         = r_bundle.cp0_we;
    assign wb_cp0_reg_write_addr = r_bundle.cp0_addr;
    assign wb_cp0_reg_data       = r_bundle.cp0_data;

`ifdef MEM_WB_PERF_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if ((w_act == MemWbActFlush || w_act == MemWbActBubble) && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            if (w_act == MemWbActHold && r_hold_cnt != 16'hFFFF)
                r_hold_cnt <= r_hold_cnt + 16'd1;
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_hold_cnt   = r_hold_cnt;
`else
    assign perf_bubble_cnt = '0;
    assign perf_hold_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage register for the 6-stage stall-vector core; successor to the single-issue MEM/WB latch.
- Carries NCH parallel register-write channels (dual-issue ready), HI/LO, LL bit and CP0 write bundles.
- Adds a flush input, a stage-valid bit, same-bundle write-collision resolution and $zero write suppression.
- Sits between the MEM stage and regfile/hilo_reg/LLbit_reg/cp0_reg write ports.

Parameters:
- NCH, 2, number of GPR write channels (1..4).
- DW, 32, data width of GPR/HI/LO/CP0 payloads.
- AW, 5, GPR address width.
- STAGE_IDX, 4, index of this stage's bit in the stall vector (0..4); STAGE_IDX+1 is the downstream bit.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  6  stall vector from ctrl; Stop=1
- flush  in  1  exception/eret flush; kills the captured bundle
- mem_valid  in  1  MEM stage holds a real instruction
- mem_wreg  in  NCH  per-channel GPR write enable
- mem_wd  in  NCH*AW  per-channel GPR address; channel i at [i*AW +: AW]
- mem_wdata  in  NCH*DW  per-channel GPR data
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  DW each  HI/LO data
- mem_LLbit_we, mem_LLbit_value  in  1 each  LL bit update
- mem_cp0_reg_we  in  1  CP0 write enable
- mem_cp0_reg_write_addr  in  5  CP0 register address
- mem_cp0_reg_data  in  DW  CP0 write data
- wb_valid  out  1  WB stage holds a real instruction
- wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_LLbit_we, wb_LLbit_value, wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data  out  widths mirror the inputs; registered bundle
- perf_bubble_cnt  out  16  bubble-insert cycle count (see Optional Feature)
- perf_hold_cnt  out  16  hold cycle count (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, including wb_valid, all enables, addresses, data and the counters.
- Each clk edge evaluates one action, in this priority order:
  1. Flush (flush=1): load a bubble. This overrides stall.
  2. Bubble (stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0): load a bubble.
  3. Capture (stall[STAGE_IDX]=0): load the MEM bundle.
  4. Hold (otherwise): all outputs keep their values.
- A bubble sets every output to 0: wb_valid, all write enables, all addresses and all data.
- Capture details:
  - wb_valid <= mem_valid.
  - If mem_valid=0, all write enables are forced to 0. Data is still captured.
- $zero suppression: channel i's wb_wreg bit is 0 whenever its captured wd equals 0.
- Collision resolution: if channels i<j both have wreg=1 with equal wd in the same bundle, channel i's wreg is cleared (the higher index wins). This is applied for every pair. The logic is combinational before the register.
- Latency: exactly 1 cycle from the MEM inputs to the WB outputs. There is no combinational path from any input to any output.
- Reset deasserting mid-stall: the first edge after release follows the normal priority order.

Optional Feature:
- Macro: MEM_WB_PERF_CNT_EN.
- Defined:
  - perf_bubble_cnt increments on each bubble or flush edge.
  - perf_hold_cnt increments on each hold edge.
  - Both counters are 16-bit, saturate at 16'hFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/defines.v already holds:
  - Stop/NoStop, WriteEnable/WriteDisable
  - ZeroWord, NOPRegAddr
  - the RegBus/RegAddrBus widths
- Add to the package: MemWbActFlush/Bubble/Capture/Hold action encoding (2-bit).
- One natural sub-module: wreg_collide (combinational; inputs NCH wreg and wd; outputs the resolved wreg). Unit-test it standalone.

Test Plan:
- Reset: assert rst=0 mid-cycle with a valid bundle loaded -> all outputs 0 immediately, without waiting for clk.
- Capture: NCH=2, stall=0, ch0 wd=3/data=32'hA5A5_0001, ch1 wd=7/data=32'h0000_1234, mem_valid=1 -> next cycle both wb_wreg bits are 1 and the data matches.
- Collision and $zero:
  - ch0 and ch1 both wd=9 -> wb_wreg=2'b10.
  - ch0 wd=0, wreg=1 -> wb_wreg bit0 is 0.
- Stall vector:
  - stall=6'b011111 -> bubble (all 0).
  - stall=6'b111111 -> outputs hold for 3 cycles unchanged.
  - stall=0 -> capture resumes.
- Flush priority: flush=1 with stall=6'b111111 and a valid bundle -> bubble. With MEM_WB_PERF_CNT_EN, perf_bubble_cnt increments by 1.
- Counter saturation (macro defined): force 70000 hold cycles -> perf_hold_cnt=16'hFFFF and stays there.
